pid_error_generator: RTL and testbench

//  Producer side of the PID error interface (error / error_ready) feeding the PID controller.
//  - Once every SAMPLE_DIV clocks, collects 2**AVG_LOG2 samples over a valid/ready handshake.
//  - Averages the samples and computes error = setpoint - average.
//  - Applies a deadband, registers the result and pulses error_ready for one cycle.

---
 rtl/pid_error_generator.sv | 148 ++++++++++++++
 tb/tb_pid_error_generator.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_error_generator.sv
// pid_error_generator: windowed-average setpoint error producer for the PID loop.
// Define ERROR_CLAMP_EN to saturate the reported error to +/-ERR_LIMIT.
module pid_error_generator #(
    parameter int DATA_W     = 12,
    parameter int AVG_LOG2   = 2,
    parameter int SAMPLE_DIV = 50000,
    parameter int DEADBAND   = 0,
    parameter int ERR_LIMIT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] meas_data,
    input  logic              meas_valid,
    output logic              meas_ready,
    output logic [31:0]       error,
    output logic              error_ready,
    output logic              overrun
);

    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic signed [31:0] DB_POS  = 32'(DEADBAND);
    localparam logic signed [31:0] DB_NEG  = 32'(-DEADBAND);
    localparam logic signed [31:0] LIM_POS = 32'(ERR_LIMIT);
    localparam logic signed [31:0] LIM_NEG = 32'(-ERR_LIMIT);

`ifdef ERROR_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        COLLECT,
        COMPUTE,
        EMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [CNT_W-1:0]  sample_cnt;
    logic [SUM_W-1:0]  sum;
    logic              handshake;
    logic              last_sample;

    logic [SUM_W-1:0]        sp_ext;
    logic [SUM_W-1:0]        avg_ext;
    logic signed [SUM_W:0]   diff;
    logic signed [31:0]      raw;

    assign tick        = enable && (tick_cnt == TICK_LAST);
    assign handshake   = meas_valid && meas_ready && (state == COLLECT);
    assign last_sample = handshake && (sample_cnt == CNT_LAST);

    // Free-running sampling divider, parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (enable) state_next = WAIT_TICK;
            WAIT_TICK: if (tick) state_next = COLLECT;
            COLLECT:   if (last_sample) state_next = COMPUTE;
            COMPUTE:   state_next = EMIT;
            EMIT:      state_next = WAIT_TICK;
            default:   state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        sp_ext  = SUM_W'(setpoint);
        avg_ext = sum >> AVG_LOG2;
        diff    = $signed({1'b0, sp_ext}) - $signed({1'b0, avg_ext});
        raw     = 32'(diff);
        if (raw <= DB_POS && raw >= DB_NEG) begin
            raw = '0;
        end
        if (CLAMP && raw > LIM_POS) begin
            raw = LIM_POS;
        end else if (CLAMP && raw < LIM_NEG) begin
            raw = LIM_NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum         <= '0;
            sample_cnt  <= '0;
            meas_ready  <= 1'b0;
            error       <= '0;
            error_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            meas_ready  <= (state_next == COLLECT);
            error_ready <= 1'b0;
            if (tick && state != WAIT_TICK) begin
                overrun <= 1'b1;
            end
            if (!enable) begin
                sum        <= '0;
                sample_cnt <= '0;
            end else if (state == WAIT_TICK && tick) begin
                sum        <= '0;
                sample_cnt <= '0;
            end else if (handshake) begin
                sum        <= sum + SUM_W'(meas_data);
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            // Result registers on the COMPUTE edge so the strobe lands in EMIT.
            if (state == COMPUTE && enable) begin
                error       <= raw;
                error_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_error_generator.sv
// tb_pid_error_generator: randomized bench with a timestamp/arithmetic reference model.
module tb_pid_error_generator;

    localparam int DATA_W     = 12;
    localparam int AVG_LOG2   = 2;
    localparam int SAMPLE_DIV = 16;
    localparam int DEADBAND   = 2;
    localparam int ERR_LIMIT  = 1000;
    localparam int WIN        = 1 << AVG_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DATA_W-1:0] setpoint;
    logic [DATA_W-1:0] meas_data;
    logic              meas_valid;
    logic              meas_ready;
    logic [31:0]       error;
    logic              error_ready;
    logic              overrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   er_count = 0;
    int   en_start = 0;
    int   next_t = 0;
    int   exp_err = 0;
    logic exp_ovr = 1'b0;
    int   smp [WIN];

    pid_error_generator #(
        .DATA_W    (DATA_W),
        .AVG_LOG2  (AVG_LOG2),
        .SAMPLE_DIV(SAMPLE_DIV),
        .DEADBAND  (DEADBAND),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .setpoint   (setpoint),
        .meas_data  (meas_data),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .error      (error),
        .error_ready(error_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (error_ready === 1'b1) er_count <= er_count + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Ticks land on edges en_start+SAMPLE_DIV-1, then every SAMPLE_DIV edges.
    function automatic int next_tick_after(int e);
        int first;
        first = en_start + SAMPLE_DIV - 1;
        if (e < first) return first;
        return first + ((e - first) / SAMPLE_DIV + 1) * SAMPLE_DIV;
    endfunction

    function automatic int model_error(int sp);
        int total;
        int r;
        total = 0;
        foreach (smp[i]) total += smp[i];
        r = sp - total / WIN;
        if (r >= -DEADBAND && r <= DEADBAND) r = 0;
`ifdef ERROR_CLAMP_EN
        if (r > ERR_LIMIT) r = ERR_LIMIT;
        if (r < -ERR_LIMIT) r = -ERR_LIMIT;
`endif
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_collect();
        while (cyc < next_t) begin
            n_cmp++;
            if (meas_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL ready_before_tick cyc=%0d got=%b want=0", cyc, meas_ready);
            end
            cycle();
        end
        n_cmp++;
        if (meas_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_at_tick cyc=%0d got=%b want=1", cyc, meas_ready);
        end
    endtask

    task automatic do_average(input int sp, input int gmin, input int gmax, input int stall);
        int t0, n_edge, er0, want, gs;
        setpoint   = DATA_W'(sp);
        meas_valid = 1'b1;
        meas_data  = DATA_W'($urandom);
        wait_collect();
        t0  = cyc;
        er0 = er_count;
        for (int i = 0; i < WIN; i++) begin
            gs = int'($urandom_range(gmax, gmin)) + ((i == 2) ? stall : 0);
            meas_valid = 1'b0;
            meas_data  = DATA_W'($urandom);
            for (int g = 0; g < gs; g++) begin
                cycle();
                n_cmp++;
                if (meas_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ready_gap cyc=%0d got=%b want=1", cyc, meas_ready);
                end
            end
            meas_valid = 1'b1;
            meas_data  = DATA_W'(smp[i]);
            cycle();
            if (i < WIN - 1) begin
                n_cmp++;
                if (meas_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ready_mid cyc=%0d got=%b want=1", cyc, meas_ready);
                end
            end
        end
        n_edge = cyc;
        meas_data = DATA_W'($urandom);
        want = model_error(sp);
        n_cmp++;
        if (meas_ready !== 1'b0 || error_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL after_last cyc=%0d ready=%b strobe=%b want=0/0", cyc, meas_ready, error_ready);
        end
        cycle();
        n_cmp++;
        if (error_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL strobe cyc=%0d got=%b want=1", cyc, error_ready);
        end
        n_cmp++;
        if (error !== want) begin
            n_bad++;
            $display("FAIL error_value got=%0d want=%0d", $signed(error), want);
        end
        meas_valid = 1'b0;
        exp_err = want;
        if (next_tick_after(t0) <= n_edge + 2) exp_ovr = 1'b1;
        cycle();
        n_cmp++;
        if (error_ready !== 1'b0 || error !== exp_err) begin
            n_bad++;
            $display("FAIL strobe_width strobe=%b error=%0d want=0/%0d", error_ready, $signed(error), exp_err);
        end
        n_cmp++;
        if (overrun !== exp_ovr) begin
            n_bad++;
            $display("FAIL overrun got=%b want=%b", overrun, exp_ovr);
        end
        n_cmp++;
        if (er_count - er0 !== 1) begin
            n_bad++;
            $display("FAIL strobe_count got=%0d want=1", er_count - er0);
        end
        next_t = next_tick_after(n_edge + 2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        meas_valid = 1'b0;
        meas_data = '0;
        setpoint = '0;
        repeat (3) cycle();
        n_cmp++;
        if (meas_ready !== 1'b0 || error !== 32'd0 || error_ready !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset ready=%b error=%0d strobe=%b ovr=%b want all 0",
                     meas_ready, error, error_ready, overrun);
        end
        rst = 1'b0;
        enable = 1'b1;
        en_start = cyc + 1;
        next_t = next_tick_after(cyc);
    endtask

    task automatic test_basic();
        smp = '{2000, 2010, 2020, 2030};
        do_average(2048, 0, 0, 0);
        n_cmp++;
        if (error !== 33) begin
            n_bad++;
            $display("FAIL basic_error got=%0d want=33", $signed(error));
        end
    endtask

    task automatic test_saturation();
        int want;
`ifdef ERROR_CLAMP_EN
        want = -1000;
`else
        want = -3995;
`endif
        smp = '{4095, 4095, 4095, 4095};
        do_average(100, 0, 0, 0);
        n_cmp++;
        if (error !== want) begin
            n_bad++;
            $display("FAIL saturation got=%0d want=%0d", $signed(error), want);
        end
    endtask

    task automatic test_deadband();
        smp = '{1002, 1002, 1002, 1002};
        do_average(1000, 0, 1, 0);
        n_cmp++;
        if (error !== 0) begin
            n_bad++;
            $display("FAIL deadband_in got=%0d want=0", $signed(error));
        end
        smp = '{1003, 1003, 1003, 1003};
        do_average(1000, 0, 1, 0);
        n_cmp++;
        if (error !== -3) begin
            n_bad++;
            $display("FAIL deadband_out got=%0d want=-3", $signed(error));
        end
    endtask

    task automatic test_flow();
        foreach (smp[i]) smp[i] = int'($urandom_range(4095, 0));
        do_average(int'($urandom_range(4095, 0)), 2, 2, 0);
    endtask

    task automatic test_stall();
        foreach (smp[i]) smp[i] = int'($urandom_range(4095, 0));
        do_average(int'($urandom_range(4095, 0)), 0, 1, 20);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_overrun got=%b want=1", overrun);
        end
    endtask

    task automatic test_abort();
        int er0;
        meas_valid = 1'b0;
        wait_collect();
        er0 = er_count;
        for (int i = 0; i < 2; i++) begin
            meas_valid = 1'b1;
            meas_data  = DATA_W'($urandom);
            cycle();
        end
        enable = 1'b0;
        meas_data = DATA_W'($urandom);
        cycle();
        n_cmp++;
        if (meas_ready !== 1'b0 || error_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ready ready=%b strobe=%b want=0/0", meas_ready, error_ready);
        end
        repeat (5) begin
            cycle();
            n_cmp++;
            if (error !== exp_err || meas_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_hold error=%0d ready=%b want=%0d/0", $signed(error), meas_ready, exp_err);
            end
        end
        n_cmp++;
        if (er_count !== er0) begin
            n_bad++;
            $display("FAIL abort_no_strobe got=%0d want=%0d", er_count, er0);
        end
        meas_valid = 1'b0;
        enable = 1'b1;
        en_start = cyc + 1;
        next_t = next_tick_after(cyc);
        foreach (smp[i]) smp[i] = int'($urandom_range(4095, 0));
        do_average(int'($urandom_range(4095, 0)), 0, 1, 0);
    endtask

    task automatic test_rst_mid();
        meas_valid = 1'b0;
        wait_collect();
        meas_valid = 1'b1;
        meas_data = DATA_W'($urandom);
        cycle();
        rst = 1'b1;
        meas_data = DATA_W'($urandom);
        cycle();
        n_cmp++;
        if (meas_ready !== 1'b0 || error !== 32'd0 || error_ready !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid ready=%b error=%0d strobe=%b ovr=%b want all 0",
                     meas_ready, error, error_ready, overrun);
        end
        exp_err = 0;
        exp_ovr = 1'b0;
        rst = 1'b0;
        meas_valid = 1'b0;
        en_start = cyc + 1;
        next_t = next_tick_after(cyc);
        foreach (smp[i]) smp[i] = int'($urandom_range(4095, 0));
        do_average(int'($urandom_range(4095, 0)), 0, 2, 0);
    endtask

    task automatic test_random(input int n);
        int total, sp;
        for (int k = 0; k < n; k++) begin
            total = 0;
            foreach (smp[i]) begin
                smp[i] = int'($urandom_range(4095, 0));
                total += smp[i];
            end
            if (k % 3 == 0) begin
                sp = total / WIN + int'($urandom_range(6, 0)) - 3;
                if (sp < 0) sp = 0;
                if (sp > 4095) sp = 4095;
            end else begin
                sp = int'($urandom_range(4095, 0));
            end
            do_average(sp, 0, 3, (k == 5) ? 18 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_deadband();
        test_flow();
        test_stall();
        test_random(8);
        test_abort();
        test_rst_mid();
        test_random(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
